// File: rtl/shift_register_seq_if.sv
// Handshake/data bundle between the control FSM (master) and shift_register_seq (slave).
// The sout signal exists only when SHREG_SOUT_EN is defined.
interface shift_register_seq_if #(
  parameter int WORD_LENGTH = 16,
  parameter int AMT_WIDTH   = 5
);
  logic [WORD_LENGTH-1:0] D;
  logic                   load;
  logic                   sync_reset;
  logic                   start;
  logic [AMT_WIDTH-1:0]   amount;
  logic [1:0]             mode;
  logic                   serial_in;
  logic [WORD_LENGTH-1:0] Q;
  logic                   busy;
  logic                   done;
`ifdef SHREG_SOUT_EN
  logic                   sout;

  modport master (output D, load, sync_reset, start, amount, mode, serial_in,
                  input  Q, busy, done, sout);
  modport slave  (input  D, load, sync_reset, start, amount, mode, serial_in,
                  output Q, busy, done, sout);
`else
  modport master (output D, load, sync_reset, start, amount, mode, serial_in,
                  input  Q, busy, done);
  modport slave  (input  D, load, sync_reset, start, amount, mode, serial_in,
                  output Q, busy, done);
`endif
endinterface

// File: rtl/shift_register_seq.sv
// Multi-cycle registered shifter: LSL/LSR/ASR/ROL by a run-time amount, up to STEP bits per cycle.
// Optional SHREG_SOUT_EN adds a registered serial-out bit (last bit shifted out).
module shift_register_seq #(
  parameter int WORD_LENGTH = 16,
  parameter int AMT_WIDTH   = 5,
  parameter int STEP        = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_register_seq_if.slave   bus
);
  localparam int WL = WORD_LENGTH;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state_q;
  logic [WL-1:0]        q_q;
  logic                 busy_q;
  logic                 done_q;
  logic [AMT_WIDTH-1:0] remaining_q;
  logic [1:0]           mode_q;

  logic [AMT_WIDTH-1:0] remaining_d;
  logic [AMT_WIDTH-1:0] step_k;
  logic [WL-1:0]        q_d;
  logic [31:0]          rem32;
  logic [WL-1:0]        stage [0:STEP];

  function automatic logic [WL-1:0] shift1(input logic [WL-1:0] v, input logic [1:0] m,
                                           input logic fill);
    case (m)
      2'b00:   return {v[WL-2:0], fill};
      2'b01:   return {fill, v[WL-1:1]};
      2'b10:   return {v[WL-1], v[WL-1:1]};
      default: return {v[WL-2:0], v[WL-1]};
    endcase
  endfunction

  assign rem32       = 32'(remaining_q);
  assign step_k      = (rem32 > 32'(STEP)) ? AMT_WIDTH'(STEP) : remaining_q;
  assign remaining_d = remaining_q - step_k;

  // A k-bit shift is k chained 1-bit shifts; stage gi is active only while gi < remaining.
  assign stage[0] = q_q;
  generate
    for (genvar gi = 0; gi < STEP; gi++) begin : g_step
      assign stage[gi+1] = (rem32 > 32'(gi)) ? shift1(stage[gi], mode_q, bus.serial_in)
                                             : stage[gi];
    end
  endgenerate
  assign q_d = stage[STEP];

`ifdef SHREG_SOUT_EN
  logic sout_q;
  logic sout_d;
  logic stage_out [0:STEP];

  assign stage_out[0] = sout_q;
  generate
    for (genvar gi = 0; gi < STEP; gi++) begin : g_sout
      // Right shifts lose the LSB, left shifts and rotate push the MSB out.
      assign stage_out[gi+1] = (rem32 > 32'(gi))
                             ? ((mode_q == 2'b01 || mode_q == 2'b10) ? stage[gi][0] : stage[gi][WL-1])
                             : stage_out[gi];
    end
  endgenerate
  assign sout_d   = stage_out[STEP];
  assign bus.sout = sout_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      q_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
      mode_q      <= 2'b00;
`ifdef SHREG_SOUT_EN
      sout_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (bus.sync_reset) begin
        state_q     <= IDLE;
        q_q         <= '0;
        busy_q      <= 1'b0;
        remaining_q <= '0;
`ifdef SHREG_SOUT_EN
        sout_q      <= 1'b0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.load) begin
              q_q <= bus.D;
`ifdef SHREG_SOUT_EN
              sout_q <= 1'b0;
`endif
            end else if (bus.start) begin
              if (bus.amount == '0) begin
                done_q <= 1'b1;
              end else begin
                mode_q      <= bus.mode;
                remaining_q <= bus.amount;
                busy_q      <= 1'b1;
                state_q     <= SHIFT;
              end
            end
          end
          SHIFT: begin
            q_q         <= q_d;
            remaining_q <= remaining_d;
`ifdef SHREG_SOUT_EN
            sout_q      <= sout_d;
`endif
            if (remaining_d == '0) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.Q    = q_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
